// File: rtl/crc_engine.sv
// Parameterised bit-serial CRC engine: one message byte per transfer, one bit per clock.
// Frames are delimited by in_first/in_last; the finished CRC is held until the consumer takes it.
module crc_engine #(
   parameter int unsigned WIDTH  = 32,
   parameter logic [31:0] POLY   = 32'h04C11DB7,
   parameter logic [31:0] INIT   = 32'hFFFFFFFF,
   parameter bit          REFIN  = 1'b1,
   parameter bit          REFOUT = 1'b1,
   parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_first,
   input  logic             in_last,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] crc_value,
   output logic             crc_valid,
   input  logic             crc_ready
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [WIDTH-1:0] C_POLY   = POLY[WIDTH-1:0];
   localparam logic [WIDTH-1:0] C_INIT   = INIT[WIDTH-1:0];
   localparam logic [WIDTH-1:0] C_XOROUT = XOROUT[WIDTH-1:0];

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_cnt;
   logic [7:0]       r_byte;
   logic             r_last;
   logic [WIDTH-1:0] r_crc;
   logic [WIDTH-1:0] r_crc_value;
   logic             r_crc_valid;

   logic             w_bit;
   logic             w_fb;
   logic [WIDTH-1:0] w_step;

   function automatic logic [WIDTH-1:0] f_finish(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] rev;
      rev = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         rev[i] = v[WIDTH-1-i];
      end
      return (REFOUT ? rev : v) ^ C_XOROUT;
   endfunction

   // ~r_cnt walks bit 7 down to bit 0 for MSB-first input
   assign w_bit  = REFIN ? r_byte[r_cnt] : r_byte[~r_cnt];
   assign w_fb   = r_crc[WIDTH-1] ^ w_bit;
   assign w_step = {r_crc[WIDTH-2:0], 1'b0} ^ (w_fb ? C_POLY : '0);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (in_valid)          w_state_nxt = SHIFT;
         SHIFT:   if (r_cnt == 3'd7)     w_state_nxt = r_last ? DONE : IDLE;
         DONE:    if (crc_ready)         w_state_nxt = IDLE;
         default:                        w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_byte      <= '0;
         r_last      <= 1'b0;
         r_crc       <= C_INIT;
         r_crc_value <= '0;
         r_crc_valid <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_byte <= in_data;
                  r_last <= in_last;
                  r_cnt  <= '0;
                  if (in_first) r_crc <= C_INIT;
               end
            end
            SHIFT: begin
               r_crc <= w_step;
               r_cnt <= r_cnt + 3'd1;
               // result is formed from the final step so it is ready on DONE entry
               if (r_cnt == 3'd7 && r_last) begin
                  r_crc_value <= f_finish(w_step);
                  r_crc_valid <= 1'b1;
               end
            end
            DONE: begin
               if (crc_ready) r_crc_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign crc_value = r_crc_value;
   assign crc_valid = r_crc_valid;

endmodule

// File: tb/tb_crc_engine.sv
// Drives four differently parameterised CRC engines with one shared byte stream and
// compares every result against a frame-level CRC reference model.
module tb_crc_engine;

   typedef logic [7:0] byte_q_t[$];

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_first, in_last, in_valid, crc_ready;

   logic        rdy_a, rdy_b, rdy_c, rdy_d;
   logic        val_a, val_b, val_c, val_d;
   logic [31:0] crc_a;
   logic [15:0] crc_b;
   logic [7:0]  crc_c;
   logic [11:0] crc_d;

   int          n_assert = 0;
   int          n_fail   = 0;
   byte_q_t     msg;
   byte_q_t     kat;

   always #5 clk = ~clk;

   crc_engine u_a (
      .clk(clk), .rst(rst), .in_data(in_data), .in_first(in_first), .in_last(in_last),
      .in_valid(in_valid), .in_ready(rdy_a), .crc_value(crc_a), .crc_valid(val_a),
      .crc_ready(crc_ready));

   crc_engine #(.WIDTH(16), .POLY(32'h1021), .INIT(32'hFFFF), .REFIN(1'b0), .REFOUT(1'b0),
                .XOROUT(32'h0)) u_b (
      .clk(clk), .rst(rst), .in_data(in_data), .in_first(in_first), .in_last(in_last),
      .in_valid(in_valid), .in_ready(rdy_b), .crc_value(crc_b), .crc_valid(val_b),
      .crc_ready(crc_ready));

   crc_engine #(.WIDTH(8), .POLY(32'h07), .INIT(32'h0), .REFIN(1'b0), .REFOUT(1'b0),
                .XOROUT(32'h0)) u_c (
      .clk(clk), .rst(rst), .in_data(in_data), .in_first(in_first), .in_last(in_last),
      .in_valid(in_valid), .in_ready(rdy_c), .crc_value(crc_c), .crc_valid(val_c),
      .crc_ready(crc_ready));

   crc_engine #(.WIDTH(12), .POLY(32'h80F), .INIT(32'hABC), .REFIN(1'b1), .REFOUT(1'b0),
                .XOROUT(32'h5A5)) u_d (
      .clk(clk), .rst(rst), .in_data(in_data), .in_first(in_first), .in_last(in_last),
      .in_valid(in_valid), .in_ready(rdy_d), .crc_value(crc_d), .crc_valid(val_d),
      .crc_ready(crc_ready));

   // Byte-at-a-time CRC over a whole frame: XOR the (optionally reflected) byte into the
   // top of the register, then eight polynomial reductions.
   function automatic logic [31:0] model(input int unsigned w, input logic [31:0] poly,
                                         input logic [31:0] init, input bit refin,
                                         input bit refout, input logic [31:0] xorout,
                                         input byte_q_t m);
      longint unsigned mask, top, r, b, o;
      mask = (64'd1 << w) - 64'd1;
      top  = 64'd1 << (w - 1);
      r    = init & mask;
      foreach (m[i]) begin
         b = 0;
         for (int j = 0; j < 8; j++) b[refin ? 7 - j : j] = m[i][j];
         r = r ^ (b << (w - 8));
         for (int j = 0; j < 8; j++)
            r = ((r & top) != 0) ? (((r << 1) ^ poly) & mask) : ((r << 1) & mask);
      end
      o = r;
      if (refout) begin
         o = 0;
         for (int j = 0; j < int'(w); j++) o[w - 1 - j] = r[j];
      end
      return 32'((o ^ xorout) & mask);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_flags(input string tag, input bit rdy, input bit val);
      check({tag, "_rdy_a"}, 32'(rdy_a), 32'(rdy));
      check({tag, "_rdy_b"}, 32'(rdy_b), 32'(rdy));
      check({tag, "_rdy_c"}, 32'(rdy_c), 32'(rdy));
      check({tag, "_rdy_d"}, 32'(rdy_d), 32'(rdy));
      check({tag, "_val_a"}, 32'(val_a), 32'(val));
      check({tag, "_val_b"}, 32'(val_b), 32'(val));
      check({tag, "_val_c"}, 32'(val_c), 32'(val));
      check({tag, "_val_d"}, 32'(val_d), 32'(val));
   endtask

   task automatic check_values(input string tag);
      check({tag, "_crc_a"}, crc_a, model(32, 32'h04C11DB7, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, msg));
      check({tag, "_crc_b"}, 32'(crc_b), model(16, 32'h1021, 32'hFFFF, 0, 0, 32'h0, msg));
      check({tag, "_crc_c"}, 32'(crc_c), model(8, 32'h07, 32'h0, 0, 0, 32'h0, msg));
      check({tag, "_crc_d"}, 32'(crc_d), model(12, 32'h80F, 32'hABC, 1, 0, 32'h5A5, msg));
   endtask

   // Called just after a negedge with in_ready=1. Returns at the negedge where the engine
   // is ready again or presents a result; junk toggles inputs while the engine is busy.
   task automatic xfer(input logic [7:0] d, input bit f, input bit l, input bit junk);
      int lat;
      in_data = d; in_first = f; in_last = l; in_valid = 1'b1;
      if (f) msg = {d};
      else   msg.push_back(d);
      @(posedge clk);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (rdy_a || val_a) begin
            lat = k;
            break;
         end
         if (junk) begin
            in_valid = 1'($urandom); in_first = 1'($urandom);
            in_last  = 1'($urandom); in_data  = 8'($urandom);
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      check("latency", 32'(lat), 32'd9);
      check_flags("post_byte", !l, l);
   endtask

   task automatic send_frame(input byte_q_t q, input bit junk);
      foreach (q[i]) xfer(q[i], i == 0, i == q.size() - 1, junk);
   endtask

   // At a negedge showing crc_valid: check the result, hold it for 'hold' cycles, handshake.
   task automatic finish_frame(input string tag, input int hold);
      logic [31:0] sa;
      check_values(tag);
      sa = crc_a;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check_flags({tag, "_hold"}, 1'b0, 1'b1);
         check({tag, "_hold_crc_a"}, crc_a, sa);
      end
      crc_ready = 1'b1;
      @(negedge clk);
      check_flags({tag, "_after"}, 1'b1, 1'b0);
      check({tag, "_kept_crc_a"}, crc_a, sa);
   endtask

   initial begin
      kat = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      rst = 1'b1; in_data = '0; in_first = 1'b0; in_last = 1'b0; in_valid = 1'b0;
      crc_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_val_a", 32'(val_a), 32'd0);
      check("rst_crc_a", crc_a, 32'd0);
      check("rst_crc_b", 32'(crc_b), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_flags("rst_release", 1'b1, 1'b0);

      // standard check vectors
      send_frame(kat, 1'b0);
      check("kat_a", crc_a, 32'hCBF43926);
      check("kat_b", 32'(crc_b), 32'h29B1);
      check("kat_c", 32'(crc_c), 32'hF4);
      finish_frame("kat", 0);

      send_frame({8'h00}, 1'b0);
      check("single00_c", 32'(crc_c), 32'h00);
      finish_frame("single00", 0);

      // consumer stalls for 20 cycles
      crc_ready = 1'b0;
      send_frame(kat, 1'b1);
      check("stall_kat_a", crc_a, 32'hCBF43926);
      finish_frame("stall", 20);

      // reset in the middle of byte 5
      for (int i = 0; i < 4; i++) xfer(kat[i], i == 0, 1'b0, 1'b0);
      in_data = kat[4]; in_first = 1'b0; in_last = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      msg = {};
      @(negedge clk);
      check_flags("abort_release", 1'b1, 1'b0);
      check("abort_crc_a", crc_a, 32'd0);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("abort_no_result", 32'(val_a | val_b | val_c | val_d), 32'd0);
      end
      send_frame(kat, 1'b0);
      check("resend_kat_a", crc_a, 32'hCBF43926);
      finish_frame("resend", 0);

      // "12" left open, then a fresh frame restarts the accumulation
      xfer(8'h31, 1'b1, 1'b0, 1'b1);
      xfer(8'h32, 1'b0, 1'b0, 1'b1);
      send_frame(kat, 1'b1);
      check("restart_kat_a", crc_a, 32'hCBF43926);
      check("restart_kat_b", 32'(crc_b), 32'h29B1);
      finish_frame("restart", 0);

      // random frames with random stalls and bus noise
      for (int f = 0; f < 8; f++) begin
         byte_q_t q;
         int      hold;
         q = {};
         for (int i = 0; i < int'($urandom_range(1, 7)); i++) q.push_back(8'($urandom));
         hold = int'($urandom_range(0, 3));
         crc_ready = (hold == 0);
         send_frame(q, 1'($urandom));
         finish_frame("rand", hold);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within the time limit");
      $fatal(1, "timeout");
   end

endmodule
